// File: rtl/ilda_frame_player_if.sv
// Bus bundle for ilda_frame_player: control, point ROM port and point output stream.
// Optional underrun_count is present when ILDA_UNDERRUN_COUNT_EN is defined.
interface ilda_frame_player_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] frame_base;
  logic [ADDR_W-1:0] frame_len;
  logic              loop_en;
  logic              next;
  logic [DATA_W-1:0] rom_dout;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              busy;
  logic              frame_done;
  logic              underrun;
  logic [1:0]        state_dbg;
`ifdef ILDA_UNDERRUN_COUNT_EN
  logic [15:0]       underrun_count;
`endif

  // Output stream: out_valid rises when a point is fetched and stays high until the
  // pacer pulses next for one cycle; that pulse consumes the point and drops out_valid.
  // A next seen while out_valid=0 and busy=1 is an underrun and consumes nothing.
  modport slave (
    input  start, stop, frame_base, frame_len, loop_en, next, rom_dout,
    output rom_address, out_data, out_valid, busy, frame_done, underrun, state_dbg
`ifdef ILDA_UNDERRUN_COUNT_EN
    , output underrun_count
`endif
  );

  modport master (
    output start, stop, frame_base, frame_len, loop_en, next, rom_dout,
    input  rom_address, out_data, out_valid, busy, frame_done, underrun, state_dbg
`ifdef ILDA_UNDERRUN_COUNT_EN
    , input underrun_count
`endif
  );
endinterface

// File: rtl/ilda_frame_player.sv
// Plays one ILDA point frame from a synchronous ROM (one-shot or loop), paced by next.
// Define ILDA_UNDERRUN_COUNT_EN to add the saturating 16-bit underrun_count output.
module ilda_frame_player #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 32,
  parameter int ROM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  ilda_frame_player_if.slave  bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [2:0] LAT      = 3'(ROM_LATENCY);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, len_q, len_d, idx_q, idx_d, addr_q, addr_d;
  logic              loop_q, loop_d;
  logic [2:0]        wait_q, wait_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d, done_q, done_d, under_q, under_d;
  logic              start_ok;

  assign start_ok = bus.start && (bus.frame_len != '0);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    loop_d  = loop_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wait_d  = wait_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    under_d = 1'b0;
    if (bus.stop) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else if (start_ok) begin
      // Restart discards any fetch in flight; the new address goes out this edge.
      state_d = ST_FETCH;
      base_d  = bus.frame_base;
      len_d   = bus.frame_len;
      loop_d  = bus.loop_en;
      idx_d   = '0;
      addr_d  = bus.frame_base;
      wait_d  = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (bus.next) under_d = 1'b1;
          if (wait_q == LAT) begin
            data_d  = bus.rom_dout;
            valid_d = 1'b1;
            state_d = ST_READY;
          end else begin
            wait_d = wait_q + 3'd1;
          end
        end
        ST_READY: begin
          if (bus.next) begin
            valid_d = 1'b0;
            wait_d  = '0;
            if (idx_q != len_q - 1'b1) begin
              idx_d   = idx_q + 1'b1;
              addr_d  = base_q + idx_d;
              state_d = ST_FETCH;
            end else begin
              done_d = 1'b1;
              if (loop_q) begin
                idx_d   = '0;
                addr_d  = base_q;
                state_d = ST_FETCH;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      idx_q   <= '0;
      addr_q  <= '0;
      wait_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      under_q <= under_d;
    end
  end

`ifdef ILDA_UNDERRUN_COUNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (!bus.stop && start_ok) ucnt_d = '0;
    else if (under_d && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ucnt_q <= '0;
    else          ucnt_q <= ucnt_d;
  end

  assign bus.underrun_count = ucnt_q;
`endif

  assign bus.rom_address = addr_q;
  assign bus.out_data    = data_q;
  assign bus.out_valid   = valid_q;
  assign bus.busy        = (state_q == ST_FETCH) || (state_q == ST_READY);
  assign bus.frame_done  = done_q;
  assign bus.underrun    = under_q;
  assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_ilda_frame_player.sv
// Bench for ilda_frame_player: directed literal checks plus randomized traffic compared
// every cycle against a timestamp-based playback model.
module tb_ilda_frame_player;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int L  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cnt = 0;
  bit   chk_en = 1'b0;

  ilda_frame_player_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ilda_frame_player #(.ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(L)) dut (
    .clk(clk), .reset_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // ROM: word = address zero-extended, valid L cycles after the address changes
  logic [AW-1:0] rom_p0, rom_p1;
  always @(posedge clk) begin
    rom_p0 <= bus.rom_address;
    rom_p1 <= rom_p0;
  end
  assign bus.rom_dout = {{(DW-AW){1'b0}}, rom_p1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: a point becomes visible L+1 cycles after its address is issued.
  bit            m_play, m_valid, m_loop, m_done, m_under;
  logic [AW-1:0] m_base, m_len, m_idx, m_addr;
  logic [DW-1:0] m_data;
  int unsigned   m_cyc, m_ready;
  logic [15:0]   m_ucnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_play = 0; m_valid = 0; m_loop = 0; m_done = 0; m_under = 0;
      m_base = '0; m_len = '0; m_idx = '0; m_addr = '0; m_data = '0;
      m_cyc = 0; m_ready = 0; m_ucnt = '0;
    end else begin
      m_cyc++;
      m_done = 0;
      m_under = 0;
      if (bus.stop) begin
        m_play = 0;
        m_valid = 0;
      end else if (bus.start && bus.frame_len != 0) begin
        m_play = 1; m_valid = 0; m_base = bus.frame_base; m_len = bus.frame_len;
        m_loop = bus.loop_en; m_idx = '0; m_addr = bus.frame_base;
        m_ready = m_cyc + L + 1; m_ucnt = '0;
      end else if (m_play) begin
        if (m_valid) begin
          if (bus.next) begin
            m_valid = 0;
            if (int'(m_idx) + 1 < int'(m_len)) begin
              m_idx = m_idx + 1'b1;
              m_addr = AW'(int'(m_base) + int'(m_idx));
              m_ready = m_cyc + L + 1;
            end else begin
              m_done = 1;
              if (m_loop) begin
                m_idx = '0; m_addr = m_base; m_ready = m_cyc + L + 1;
              end else begin
                m_play = 0;
              end
            end
          end
        end else begin
          if (bus.next) begin
            m_under = 1;
            if (m_ucnt != 16'hFFFF) m_ucnt++;
          end
          if (m_cyc == m_ready) begin
            m_valid = 1;
            m_data = {{(DW-AW){1'b0}}, m_addr};
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.frame_done) done_cnt++;
    if (rst_n && chk_en) begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("busy", 32'(bus.busy), 32'(m_play));
      chk("frame_done", 32'(bus.frame_done), 32'(m_done));
      chk("underrun", 32'(bus.underrun), 32'(m_under));
      chk("rom_address", 32'(bus.rom_address), 32'(m_addr));
      chk("out_data", bus.out_data, m_data);
`ifdef ILDA_UNDERRUN_COUNT_EN
      chk("underrun_count", 32'(bus.underrun_count), 32'(m_ucnt));
`endif
    end
  end

  // Driver tasks: called at a falling edge, return at the next falling edge.
  task automatic start_pulse(input logic [AW-1:0] b, input logic [AW-1:0] n, input bit lp);
    bus.frame_base = b; bus.frame_len = n; bus.loop_en = lp; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_next;
    bus.next = 1'b1;
    @(negedge clk);
    bus.next = 1'b0;
  endtask

  task automatic pulse_stop;
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!bus.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.out_valid) chk({name, "_timeout"}, 32'(bus.out_valid), 32'd1);
  endtask

  logic [AW-1:0] loop_exp [9];
  int d0;

  initial begin
    loop_exp = '{11'h7FE, 11'h7FF, 11'h000, 11'h001, 11'h7FE, 11'h7FF, 11'h000, 11'h001, 11'h7FE};
    bus.start = 0; bus.stop = 0; bus.next = 0; bus.loop_en = 0;
    bus.frame_base = '0; bus.frame_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(bus.rom_address), 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // one-shot frame, first point L+1 cycles after start
    d0 = done_cnt;
    start_pulse(11'h010, 11'd3, 1'b0);
    repeat (2) @(negedge clk);
    chk("lat_early", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_first", 32'(bus.out_valid), 32'd1);
    chk("p0", bus.out_data, 32'h10);
    for (int i = 1; i < 3; i++) begin
      pulse_next;
      repeat (9) @(negedge clk);
      wait_valid("oneshot");
      chk("oneshot_pt", bus.out_data, 32'h10 + 32'(i));
    end
    pulse_next;
    repeat (3) @(negedge clk);
    chk("oneshot_done", 32'(done_cnt - d0), 32'd1);
    chk("oneshot_idle", 32'(bus.busy), 32'd0);

    // loop with address wrap
    d0 = done_cnt;
    start_pulse(11'h7FE, 11'd4, 1'b1);
    for (int i = 0; i < 9; i++) begin
      wait_valid("loop");
      chk("loop_pt", bus.out_data, 32'(loop_exp[i]));
      pulse_next;
      repeat (2) @(negedge clk);
    end
    chk("loop_done", 32'(done_cnt - d0), 32'd2);
    pulse_stop;

    // next during fetch -> underrun, index unchanged
    start_pulse(11'h020, 11'd4, 1'b0);
    wait_valid("ur");
    pulse_next;
    pulse_next;
    chk("underrun_pulse", 32'(bus.underrun), 32'd1);
`ifdef ILDA_UNDERRUN_COUNT_EN
    chk("ucnt_one", 32'(bus.underrun_count), 32'd1);
`endif
    wait_valid("ur2");
    chk("ur_idx", bus.out_data, 32'h21);
    @(negedge clk);
    chk("underrun_clear", 32'(bus.underrun), 32'd0);
    pulse_stop;

    // zero-length start ignored
    start_pulse(11'h030, 11'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("len0_busy", 32'(bus.busy), 32'd0);
    chk("len0_valid", 32'(bus.out_valid), 32'd0);
`ifdef ILDA_UNDERRUN_COUNT_EN
    start_pulse(11'h030, 11'd1, 1'b0);
    chk("ucnt_clear", 32'(bus.underrun_count), 32'd0);
    pulse_stop;
`endif

    // stop wins over next in READY
    d0 = done_cnt;
    start_pulse(11'h040, 11'd1, 1'b0);
    wait_valid("stopnext");
    bus.stop = 1'b1; bus.next = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0; bus.next = 1'b0;
    chk("stop_busy", 32'(bus.busy), 32'd0);
    chk("stop_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("stop_nodone", 32'(done_cnt - d0), 32'd0);
    start_pulse(11'h100, 11'd2, 1'b0);
    wait_valid("after_stop");
    chk("after_stop_pt", bus.out_data, 32'h100);

    // asynchronous reset mid-fetch
    start_pulse(11'h055, 11'd3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr", 32'(bus.rom_address), 32'h0);
    chk("arst_data", bus.out_data, 32'h0);
    chk("arst_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_busy", 32'(bus.busy), 32'h0);
    chk("arst_done", 32'(bus.frame_done), 32'h0);
    chk("arst_under", 32'(bus.underrun), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", 32'(bus.busy), 32'd0);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      bus.stop = (r < 2);
      if (r >= 2 && r < 7) begin
        bus.start = 1'b1;
        bus.frame_base = ($urandom_range(0, 1) == 0) ? AW'($urandom) : AW'(11'h7FC + AW'($urandom_range(0, 3)));
        bus.frame_len = AW'($urandom_range(0, 5));
        bus.loop_en = $urandom_range(0, 1) == 1;
      end
      bus.next = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      bus.stop = 0; bus.start = 0; bus.next = 0;
    end
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ilda_frame_player.md
Name: ilda_frame_player

Overview:
- Parametrised successor to the single-frame ROM point player in the laser projector path.
- Plays one ILDA point frame from a synchronous point ROM, given a base address and a point count.
- Supports one-shot and loop modes, a configurable ROM read latency and a registered output with valid.
- Sits between the pattern ROM and the galvo/DAC point-rate pacer, which issues `next` pulses.

Parameters:
- ADDR_W, 11: ROM address width; frame base/length width.
- DATA_W, 32: point word width (ROM dout and out_data).
- ROM_LATENCY, 1: cycles from rom_address change to valid rom_dout; legal range 1..4.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches frame_base/frame_len/loop_en and begins playback
- stop  in  1  one-cycle pulse; abort to IDLE
- frame_base  in  ADDR_W  first point address of frame
- frame_len  in  ADDR_W  number of points in frame (0 = invalid)
- loop_en  in  1  1 = replay frame indefinitely, 0 = one-shot
- next  in  1  one-cycle pulse from pacer: consume current point
- rom_dout  in  DATA_W  point ROM data
- rom_address  out  ADDR_W  point ROM address
- out_data  out  DATA_W  current point word
- out_valid  out  1  out_data holds a fetched, unconsumed point
- busy  out  1  high in FETCH or READY
- frame_done  out  1  one-cycle pulse after the last point of a pass is consumed
- underrun  out  1  one-cycle pulse when next arrives while out_valid=0 and busy=1

Behaviour:
- Reset (async assert, sync release): state IDLE; rom_address=0, out_data=0, out_valid=0, busy=0, frame_done=0, underrun=0, index=0.
- States:
  - IDLE → FETCH on start with frame_len≠0. Latch base, len and loop; index=0.
  - start with frame_len=0 is ignored; stay IDLE.
  - FETCH: rom_address=base+index, registered and wrapping modulo 2^ADDR_W. A wait counter runs ROM_LATENCY cycles. On the cycle rom_dout is valid, capture it into out_data, set out_valid=1 and go to READY.
  - READY, on next: clear out_valid.
    - If index≠len-1: index+1, go to FETCH.
    - Else pulse frame_done. With loop=1: index=0, go to FETCH. With loop=0: go to IDLE.
- Latency: start at cycle T puts the first point on out_data with out_valid=1 at T+1+ROM_LATENCY. Each next in READY gives the following point ROM_LATENCY+1 cycles later.
- out_data holds its last value when out_valid=0 and in IDLE; it is not cleared except by reset.
- next outside READY:
  - During FETCH: ignored, underrun pulses.
  - In IDLE: ignored, no underrun.
- start while busy restarts immediately from the new base/len. Any in-flight fetch is discarded, out_valid clears, no frame_done.
- stop has priority over start and next in the same cycle. It goes to IDLE, clears out_valid and busy, and gives no frame_done.
- Loop-mode wrap: frame_done pulses on every pass. No gap beyond the normal refetch.
- loop_en is sampled only at start.
- busy=1 exactly in FETCH/READY.
- A reset_n assert mid-fetch returns to reset values immediately.

Optional Feature:
- Macro ILDA_UNDERRUN_COUNT_EN.
- Defined: adds output underrun_count[15:0]. It increments on each underrun pulse, saturates at 16'hFFFF, clears on reset and on start.
- Undefined: port and counter absent; underrun pulse is unchanged.

Test Plan:
- ROM model with data={addr} zero-extended, ROM_LATENCY=2. Reset, then start base=0x010 len=3 loop=0, next every 10 cycles → out_data 0x10, 0x11, 0x12 in order. First out_valid 3 cycles after start. frame_done once after the third next, then busy=0.
- loop=1, base=0x7FE, len=4 → addresses 0x7FE, 0x7FF, 0x000, 0x001, 0x7FE…; frame_done after every 4th next.
- next one cycle after consuming a point (during FETCH) → underrun=1 for one cycle, index unchanged. With ILDA_UNDERRUN_COUNT_EN, underrun_count=1; after a new start, 0.
- start with len=0 → remains IDLE, busy=0, out_valid=0.
- stop and next in the same READY cycle → IDLE, no frame_done, out_valid=0. A following start with base=0x100 gives out_data=0x100.
- Assert reset_n low mid-FETCH → all outputs at reset values asynchronously. After release, IDLE until start.
